// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receive path.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } ps2_rx_state_t;

  localparam int FRAME_DATA_BITS = 8;

  localparam logic [7:0] KEY_RELEASE = 8'hF0;
  localparam logic [7:0] KEY_ENTER   = 8'h5A;
  localparam logic [7:0] KEY_A       = 8'h1C;
  localparam logic [7:0] KEY_W       = 8'h1D;
  localparam logic [7:0] KEY_S       = 8'h1B;
  localparam logic [7:0] KEY_D       = 8'h23;
  localparam logic [7:0] KEY_L       = 8'h4B;
  localparam logic [7:0] KEY_R       = 8'h2D;

  // PS/2 uses odd parity over the data byte plus parity bit
  function automatic logic odd_ok(
    input logic [7:0] b,
    input logic       p
  );
    return ^{b, p};
  endfunction

endpackage

// File: rtl/ps2_frame_rx_line_filter.sv
// Two-flop synchroniser plus persistence filter for one PS/2 line.
// Output idles high, matching the bus pull-up.
module ps2_line_filter
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN = 8
) (
  input  logic clk_pix,
  input  logic sim_rst,
  input  logic line,
  output logic filtered
);

  logic       sync_a;
  logic       sync_b;
  logic [7:0] cnt;

  always_ff @(posedge clk_pix or posedge sim_rst) begin
    if (sim_rst) begin
      sync_a   <= 1'b1;
      sync_b   <= 1'b1;
      filtered <= 1'b1;
      cnt      <= '0;
    end else begin
      sync_a <= line;
      sync_b <= sync_a;
      if (sync_b == filtered) begin
        cnt <= '0;
      end else if (cnt == 8'(FILTER_LEN - 1)) begin
        filtered <= sync_b;
        cnt      <= '0;
      end else begin
        cnt <= cnt + 8'd1;
      end
    end
  end

endmodule

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: filtered clk/data, 11-bit frame assembly,
// parity/stop/timeout checks and a 32-bit scan-code history.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic        clk_pix,
  input  logic        sim_rst,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [7:0]  scan_code,
  output logic        scan_valid,
  output logic [31:0] keycode_hist,
  output logic        parity_err,
  output logic        frame_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic          clk_f;
  logic          data_f;
  logic          clk_prev;
  logic          fall;
  logic          bit_d;
  ps2_rx_state_t state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par;
  logic [TW-1:0] tcnt;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_flt (
    .clk_pix  (clk_pix),
    .sim_rst  (sim_rst),
    .line     (ps2_clk),
    .filtered (clk_f)
  );

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_flt (
    .clk_pix  (clk_pix),
    .sim_rst  (sim_rst),
    .line     (ps2_data),
    .filtered (data_f)
  );

  always_ff @(posedge clk_pix or posedge sim_rst) begin
    if (sim_rst) begin
      clk_prev     <= 1'b1;
      fall         <= 1'b0;
      bit_d        <= 1'b1;
      state        <= IDLE;
      bit_cnt      <= '0;
      shreg        <= '0;
      par          <= 1'b0;
      tcnt         <= '0;
      scan_code    <= '0;
      scan_valid   <= 1'b0;
      keycode_hist <= '0;
      parity_err   <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      clk_prev   <= clk_f;
      fall       <= clk_prev & ~clk_f;
      bit_d      <= data_f;
      scan_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      if (fall) begin
        tcnt <= '0;
        unique case (state)
          IDLE: begin
            if (!bit_d) begin
              state   <= DATA;
              bit_cnt <= '0;
              shreg   <= '0;
            end
          end
          DATA: begin
            shreg   <= {bit_d, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'(FRAME_DATA_BITS - 1)) state <= PARITY;
          end
          PARITY: begin
            par   <= bit_d;
            state <= STOP;
          end
          STOP: begin
            state <= IDLE;
            if (!bit_d) begin
              frame_err <= 1'b1;
            end else if (odd_ok(shreg, par)) begin
              scan_code    <= shreg;
              scan_valid   <= 1'b1;
              keycode_hist <= {keycode_hist[23:0], shreg};
            end else begin
              parity_err <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end else if (state != IDLE) begin
        // stalled frame: drop the partial byte once the gap is too long
        if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
          frame_err <= 1'b1;
          state     <= IDLE;
        end else begin
          tcnt <= tcnt + 1'b1;
        end
      end
    end
  end

endmodule
